regfile_operand_reader: RTL and testbench

Read-side sequencer for the 32x64 ARM register file. It accepts a two-operand read request (Ra, Rb) and fetches both operands through the file's single combinational read port over successive cycles. X31 is treated as XZR. It returns both 64-bit operands on a valid/ready output handshake. It sits between decode and the register file's read mux, opposite the per-register write path.

---
 rtl/regfile_operand_reader.sv | 127 ++++++++++++
 tb/tb_regfile_operand_reader.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_operand_reader.sv
// Read-side sequencer: fetches Ra then Rb through the register file's single read port; X31 reads as zero.
// Optional same-edge write forwarding is enabled by defining REGFILE_READ_BYPASS_EN.
module regfile_operand_reader #(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 31
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] DataA,
  output logic [DATA_W-1:0] DataB
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD_A = 2'd1;
  localparam logic [1:0] S_RD_B = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  localparam logic [ADDR_W-1:0] ZR        = ADDR_W'(ZERO_REG);
  localparam logic [DATA_W-1:0] ZERO_DATA = '0;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] ra_q, ra_d;
  logic [ADDR_W-1:0] rb_q, rb_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic              fwd_a, fwd_b;

`ifdef REGFILE_READ_BYPASS_EN
  // A write landing on the capture edge wins over the stale read-port value.
  assign fwd_a = wr_en && (wr_addr == ra_q) && (ra_q != ZR);
  assign fwd_b = wr_en && (wr_addr == rb_q) && (rb_q != ZR);
`else
  logic unused_wr_snoop;
  assign unused_wr_snoop = ^{wr_en, wr_addr};
  assign fwd_a = 1'b0;
  assign fwd_b = 1'b0;
`endif

  // Next-state and operand capture
  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    a_d     = a_q;
    b_d     = b_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          ra_d = ra_addr;
          rb_d = rb_addr;
          if (ra_addr != ZR) begin
            state_d = S_RD_A;
          end else begin
            a_d = ZERO_DATA;
            if (rb_addr == ZR) begin
              b_d     = ZERO_DATA;
              state_d = S_HOLD;
            end else begin
              state_d = S_RD_B;
            end
          end
        end
      end
      S_RD_A: begin
        a_d = fwd_a ? wr_data : rd_data;
        if (rb_q == ZR) begin
          b_d     = ZERO_DATA;
          state_d = S_HOLD;
        end else begin
          state_d = S_RD_B;
        end
      end
      S_RD_B: begin
        b_d     = fwd_b ? wr_data : rd_data;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  // Read port parks on XZR outside the fetch states
  always_comb begin
    rd_addr = ZR;
    case (state_q)
      S_RD_A:  rd_addr = ra_q;
      S_RD_B:  rd_addr = rb_q;
      default: rd_addr = ZR;
    endcase
  end

  assign req_ready = (state_q == S_IDLE);
  assign out_valid = (state_q == S_HOLD);
  assign DataA     = a_q;
  assign DataB     = b_q;

endmodule

// File: tb/tb_regfile_operand_reader.sv
// Scoreboard bench for regfile_operand_reader: file model drives rd_data, expected operands queued at request time.
module tb_regfile_operand_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  ra_addr, rb_addr, rd_addr, wr_addr;
  logic [63:0] rd_data, wr_data, DataA, DataB;
  logic        wr_en, out_valid, out_ready;

`ifdef REGFILE_READ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic [63:0]  rf [32];
  logic         noise_en;
  logic [63:0]  noise;
  logic [127:0] sb [$];
  int           n_cmp = 0;
  int           n_bad = 0;

  regfile_operand_reader dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .out_valid(out_valid), .out_ready(out_ready), .DataA(DataA), .DataB(DataB)
  );

  always #5 clk = ~clk;

  assign rd_data = noise_en ? noise : rf[rd_addr];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives a request and queues the operands the file model holds now
  task automatic send(input logic [4:0] ra, input logic [4:0] rb);
    req_valid = 1'b1;
    ra_addr   = ra;
    rb_addr   = rb;
    sb.push_back({(ra == 5'd31) ? 64'd0 : rf[ra], (rb == 5'd31) ? 64'd0 : rf[rb]});
  endtask

  task automatic test_reset();
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if ({DataA, DataB} !== 128'd0) begin n_bad++; $display("FAIL reset_data: got %h_%h expected 0", DataA, DataB); end
    n_cmp++; if (rd_addr !== 5'd31) begin n_bad++; $display("FAIL reset_rd_addr: got %0d expected 31", rd_addr); end
  endtask

  task automatic test_basic();
    logic [127:0] exp;
    rf[3] = 64'h1111_2222_3333_4444;
    rf[7] = 64'hAAAA_BBBB_CCCC_DDDD;
    out_ready = 1'b1;
    send(5'd3, 5'd7);
    step();
    req_valid = 1'b0;
    n_cmp++; if (rd_addr !== 5'd3) begin n_bad++; $display("FAIL basic_rd_a: got %0d expected 3", rd_addr); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_early_valid: got %b expected 0", out_valid); end
    step();
    n_cmp++; if (rd_addr !== 5'd7) begin n_bad++; $display("FAIL basic_rd_b: got %0d expected 7", rd_addr); end
    step();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid_3edges: got %b expected 1", out_valid); end
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL basic_ready_hold: got %b expected 0", req_ready); end
    n_cmp++; if (rd_addr !== 5'd31) begin n_bad++; $display("FAIL basic_rd_park: got %0d expected 31", rd_addr); end
    if (sb.size() == 0) begin n_cmp++; n_bad++; $display("FAIL basic_result: got output expected none queued"); end
    else begin
      exp = sb.pop_front();
      n_cmp++; if ({DataA, DataB} !== exp) begin n_bad++; $display("FAIL basic_result: got %h_%h expected %h", DataA, DataB, exp); end
    end
    step();
    n_cmp++; if (req_ready !== 1'b1 || out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_back_idle: got ready=%b valid=%b expected 1/0", req_ready, out_valid); end
  endtask

  task automatic test_x31();
    logic [127:0] exp;
    rf[5] = 64'h5;
    out_ready = 1'b1;
    send(5'd31, 5'd5);
    step();
    req_valid = 1'b0;
    n_cmp++; if (rd_addr !== 5'd5) begin n_bad++; $display("FAIL x31a_rd_b: got %0d expected 5", rd_addr); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL x31a_early_valid: got %b expected 0", out_valid); end
    step();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL x31a_valid_2edges: got %b expected 1", out_valid); end
    if (sb.size() == 0) begin n_cmp++; n_bad++; $display("FAIL x31a_result: got output expected none queued"); end
    else begin
      exp = sb.pop_front();
      n_cmp++; if ({DataA, DataB} !== exp) begin n_bad++; $display("FAIL x31a_result: got %h_%h expected %h", DataA, DataB, exp); end
    end
    step();
    send(5'd31, 5'd31);
    step();
    req_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL x31b_valid_1edge: got %b expected 1", out_valid); end
    n_cmp++; if (rd_addr !== 5'd31) begin n_bad++; $display("FAIL x31b_rd_park: got %0d expected 31", rd_addr); end
    if (sb.size() == 0) begin n_cmp++; n_bad++; $display("FAIL x31b_result: got output expected none queued"); end
    else begin
      exp = sb.pop_front();
      n_cmp++; if ({DataA, DataB} !== exp) begin n_bad++; $display("FAIL x31b_result: got %h_%h expected %h", DataA, DataB, exp); end
    end
    step();
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL x31b_back_idle: got %b expected 1", req_ready); end
  endtask

  task automatic test_hold();
    logic [127:0] exp;
    out_ready = 1'b0;
    send(5'd3, 5'd7);
    step();
    req_valid = 1'b0;
    step();
    step();
    exp = sb[0];
    // Read-port noise and writes to X3 must not disturb a held result
    for (int i = 0; i < 5; i++) begin
      noise_en = 1'b1;
      noise    = {$urandom, $urandom};
      wr_en    = 1'b1;
      wr_addr  = 5'd3;
      wr_data  = {$urandom, $urandom};
      n_cmp++; if (out_valid !== 1'b1 || req_ready !== 1'b0) begin n_bad++; $display("FAIL hold_flags[%0d]: got valid=%b ready=%b expected 1/0", i, out_valid, req_ready); end
      n_cmp++; if ({DataA, DataB} !== exp) begin n_bad++; $display("FAIL hold_data[%0d]: got %h_%h expected %h", i, DataA, DataB, exp); end
      step();
      rf[3] = wr_data;
    end
    noise_en  = 1'b0;
    wr_en     = 1'b0;
    out_ready = 1'b1;
    if (sb.size() == 0) begin n_cmp++; n_bad++; $display("FAIL hold_result: got output expected none queued"); end
    else begin
      exp = sb.pop_front();
      n_cmp++; if (out_valid !== 1'b1 || {DataA, DataB} !== exp) begin n_bad++; $display("FAIL hold_result: got v=%b %h_%h expected %h", out_valid, DataA, DataB, exp); end
    end
    step();
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL hold_back_idle: got %b expected 1", req_ready); end
  endtask

  task automatic test_bypass();
    logic [127:0] exp;
    logic [63:0]  old_v;
    logic [63:0]  b_v;
    rf[3] = 64'h1111_2222_3333_4444;
    out_ready = 1'b1;
    // Write to X3 on the RD_A edge
    send(5'd3, 5'd7);
    void'(sb.pop_back());
    b_v = rf[7];
    step();
    req_valid = 1'b0;
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'hDEAD_BEEF_0000_0001;
    step();
    wr_en = 1'b0;
    old_v = rf[3];
    rf[3] = wr_data;
    sb.push_back({BYP ? 64'hDEAD_BEEF_0000_0001 : old_v, b_v});
    step();
    if (sb.size() == 0) begin n_cmp++; n_bad++; $display("FAIL bypass_a: got output expected none queued"); end
    else begin
      exp = sb.pop_front();
      n_cmp++; if (out_valid !== 1'b1 || {DataA, DataB} !== exp) begin n_bad++; $display("FAIL bypass_a: got v=%b %h_%h expected %h", out_valid, DataA, DataB, exp); end
    end
    step();
    // Write to X3 on the RD_B edge
    send(5'd7, 5'd3);
    void'(sb.pop_back());
    b_v = rf[7];
    step();
    req_valid = 1'b0;
    step();
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'h0123_4567_89AB_CDEF;
    step();
    wr_en = 1'b0;
    old_v = rf[3];
    rf[3] = wr_data;
    sb.push_back({b_v, BYP ? 64'h0123_4567_89AB_CDEF : old_v});
    if (sb.size() == 0) begin n_cmp++; n_bad++; $display("FAIL bypass_b: got output expected none queued"); end
    else begin
      exp = sb.pop_front();
      n_cmp++; if (out_valid !== 1'b1 || {DataA, DataB} !== exp) begin n_bad++; $display("FAIL bypass_b: got v=%b %h_%h expected %h", out_valid, DataA, DataB, exp); end
    end
    step();
    // A write to X31 is never forwarded
    send(5'd3, 5'd7);
    step();
    req_valid = 1'b0;
    wr_en = 1'b1; wr_addr = 5'd31; wr_data = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    wr_en = 1'b0;
    step();
    if (sb.size() == 0) begin n_cmp++; n_bad++; $display("FAIL bypass_x31: got output expected none queued"); end
    else begin
      exp = sb.pop_front();
      n_cmp++; if (out_valid !== 1'b1 || {DataA, DataB} !== exp) begin n_bad++; $display("FAIL bypass_x31: got v=%b %h_%h expected %h", out_valid, DataA, DataB, exp); end
    end
    step();
  endtask

  task automatic test_reset_mid();
    logic [127:0] exp;
    out_ready = 1'b1;
    send(5'd3, 5'd7);
    step();
    req_valid = 1'b0;
    step();
    #2 reset = 1'b0;
    #1;
    void'(sb.pop_back());
    n_cmp++; if ({DataA, DataB} !== 128'd0) begin n_bad++; $display("FAIL rstmid_data: got %h_%h expected 0", DataA, DataB); end
    n_cmp++; if (out_valid !== 1'b0 || req_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_flags: got valid=%b ready=%b expected 0/1", out_valid, req_ready); end
    #3 reset = 1'b1;
    step();
    rf[1] = 64'h0000_0001_0000_0001;
    rf[2] = 64'h0000_0002_0000_0002;
    send(5'd1, 5'd2);
    step();
    req_valid = 1'b0;
    step();
    step();
    if (sb.size() == 0) begin n_cmp++; n_bad++; $display("FAIL rstmid_after: got output expected none queued"); end
    else begin
      exp = sb.pop_front();
      n_cmp++; if (out_valid !== 1'b1 || {DataA, DataB} !== exp) begin n_bad++; $display("FAIL rstmid_after: got v=%b %h_%h expected %h", out_valid, DataA, DataB, exp); end
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [127:0] exp;
    int acc_cyc [4];
    int k   = 0;
    int cyc = 0;
    bit acc;
    out_ready = 1'b1;
    send(5'd1, 5'd2);
    while ((k < 4 || sb.size() > 0) && cyc < 40) begin
      acc = 1'b0;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin n_cmp++; n_bad++; $display("FAIL b2b_result: got extra output %h_%h expected none", DataA, DataB); end
        else begin
          exp = sb.pop_front();
          n_cmp++; if ({DataA, DataB} !== exp) begin n_bad++; $display("FAIL b2b_result: got %h_%h expected %h", DataA, DataB, exp); end
        end
      end
      if (req_ready && req_valid && k < 4) begin acc_cyc[k] = cyc; k++; acc = 1'b1; end
      step();
      cyc++;
      if (acc) begin
        if (k < 4) send(5'(2 * k + 1), 5'(2 * k + 2));
        else       req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    n_cmp++; if (k != 4 || sb.size() != 0) begin n_bad++; $display("FAIL b2b_count: got accepted=%0d pending=%0d expected 4/0", k, sb.size()); end
    for (int i = 1; i < 4; i++) begin
      n_cmp++; if (acc_cyc[i] - acc_cyc[i-1] != 4) begin n_bad++; $display("FAIL b2b_interval[%0d]: got %0d expected 4", i, acc_cyc[i] - acc_cyc[i-1]); end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; req_valid = 1'b0; ra_addr = '0; rb_addr = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; out_ready = 1'b0;
    noise_en = 1'b0; noise = '0;
    for (int i = 0; i < 32; i++) rf[i] = 64'h0101_0101_0101_0101 * 64'(i) + 64'h1000;
    rf[31] = '0;
    #12;
    test_reset();
    reset = 1'b1;
    step();
    test_basic();
    test_x31();
    test_hold();
    test_bypass();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
